// File: rtl/output_row_writer.sv
// rtl/output_row_writer.sv - packs 1-bit convolution results into row words and writes them to output SRAM
// Commits happen on controller strobes; a terminator word closes each run.
module output_row_writer #(
  parameter int                DATA_W        = 16,
  parameter int                ADDR_W        = 12,
  parameter logic [ADDR_W-1:0] OUT_BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] TERM_WORD     = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              conv_valid,
  input  logic              conv_bit,
  input  logic              str_temp_to_write,
  input  logic              rst_output_row_temp,
  input  logic              incr_output_addr,
  input  logic              end_condition_met,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic              writer_busy,
  output logic              writer_done,
  output logic              col_overflow
);

  localparam int CP_W  = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CP_W-1:0] LAST_COL  = CP_W'(DATA_W - 1);
  localparam logic [CP_W-1:0] FULL_COLS = CP_W'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_TERM,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_row_temp;
  logic [CP_W-1:0]     r_col_ptr;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_wr_en;
  logic                r_done;
  logic                r_overflow;

  logic                w_active;
  logic                w_has_room;
  logic                w_take_bit;
  logic                w_overflow_hit;
  logic                w_commit;
  logic                w_incr;
  logic [CP_W-1:0]     w_bit_pos;
  logic [DATA_W-1:0]   w_merged;
  logic [ADDR_W-1:0]   w_addr_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_ACTIVE;
      S_ACTIVE: if (end_condition_met) w_state_next = S_TERM;
      S_TERM:   w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // A row clear in the same cycle as a result drops that result, even for a commit.
  assign w_active       = (r_state == S_ACTIVE);
  assign w_has_room     = (r_col_ptr < FULL_COLS);
  assign w_take_bit     = w_active && conv_valid && !rst_output_row_temp && w_has_room;
  assign w_overflow_hit = w_active && conv_valid && !rst_output_row_temp && !w_has_room;
  assign w_commit       = w_active && str_temp_to_write;
  assign w_incr         = w_active && incr_output_addr;
  assign w_bit_pos      = LAST_COL - r_col_ptr;
  assign w_addr_next    = r_out_addr + ADDR_W'(w_commit) + ADDR_W'(w_incr);

  always_comb begin
    w_merged = r_row_temp;
    if (w_take_bit) w_merged[w_bit_pos[IDX_W-1:0]] = conv_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_row_temp <= '0;
      r_col_ptr  <= '0;
      r_out_addr <= OUT_BASE_ADDR;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row_temp <= '0;
            r_col_ptr  <= '0;
            r_overflow <= 1'b0;
            r_out_addr <= OUT_BASE_ADDR;
          end
        end
        S_ACTIVE: begin
          if (w_commit) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_out_addr;
            r_wr_data <= w_merged;
          end
          r_out_addr <= w_addr_next;
          if (w_commit || rst_output_row_temp) begin
            r_row_temp <= '0;
            r_col_ptr  <= '0;
          end else if (w_take_bit) begin
            r_row_temp <= w_merged;
            r_col_ptr  <= r_col_ptr + 1'b1;
          end
          if (w_overflow_hit) r_overflow <= 1'b1;
        end
        S_TERM: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_out_addr;
          r_wr_data <= TERM_WORD;
        end
        S_DONE:  r_done <= 1'b1;
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign dut_sram_write_address = r_wr_addr;
  assign dut_sram_write_data    = r_wr_data;
  assign dut_sram_write_enable  = r_wr_en;
  assign writer_busy            = (r_state == S_ACTIVE) || (r_state == S_TERM);
  assign writer_done            = r_done;
  assign col_overflow           = r_overflow;

endmodule

// File: tb/tb_output_row_writer.sv
// tb/tb_output_row_writer.sv - randomized and directed bench for output_row_writer
// Expected writes come from a queue-of-bits row model with plain address arithmetic.
module tb_output_row_writer;

  logic        clk = 1'b0;
  logic        reset, start, conv_valid, conv_bit;
  logic        str_temp_to_write, rst_output_row_temp, incr_output_addr, end_condition_met;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;
  logic        dut_sram_write_enable, writer_busy, writer_done, col_overflow;

  always #5 clk = ~clk;

  output_row_writer dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .conv_valid            (conv_valid),
    .conv_bit              (conv_bit),
    .str_temp_to_write     (str_temp_to_write),
    .rst_output_row_temp   (rst_output_row_temp),
    .incr_output_addr      (incr_output_addr),
    .end_condition_met     (end_condition_met),
    .dut_sram_write_address(dut_sram_write_address),
    .dut_sram_write_data   (dut_sram_write_data),
    .dut_sram_write_enable (dut_sram_write_enable),
    .writer_busy           (writer_busy),
    .writer_done           (writer_done),
    .col_overflow          (col_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run phase: 0 idle, 1 collecting rows, 2 terminator pending, 3 done pulse pending
  int          m_phase;
  bit          m_bits[$];
  logic [11:0] m_addr;
  bit          m_ovf;
  bit          e_we, e_done;
  logic [11:0] e_addr;
  logic [15:0] e_data;

  function automatic logic [15:0] pack_row();
    logic [15:0] w = '0;
    foreach (m_bits[i]) if (m_bits[i]) w = w | (16'h8000 >> i);
    return w;
  endfunction

  task automatic model_cycle(input bit s, cv, cb, st, rr, inc, ec);
    e_we = 1'b0;
    e_done = 1'b0;
    case (m_phase)
      0: if (s) begin
        m_phase = 1;
        m_bits.delete();
        m_addr = 12'h000;
        m_ovf = 1'b0;
      end
      1: begin
        if (cv && !rr) begin
          if (m_bits.size() < 16) m_bits.push_back(cb);
          else m_ovf = 1'b1;
        end
        if (st) begin
          e_we = 1'b1;
          e_addr = m_addr;
          e_data = pack_row();
          m_bits.delete();
        end
        if (rr) m_bits.delete();
        m_addr = m_addr + 12'(st) + 12'(inc);
        if (ec) m_phase = 2;
      end
      2: begin
        e_we = 1'b1;
        e_addr = m_addr;
        e_data = 16'h00FF;
        m_phase = 3;
      end
      default: begin
        e_done = 1'b1;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic compare_outputs();
    check_eq("we", dut_sram_write_enable, e_we);
    check_eq("busy", writer_busy, (m_phase == 1 || m_phase == 2));
    check_eq("done", writer_done, e_done);
    check_eq("overflow", col_overflow, m_ovf);
    if (e_we) begin
      check_eq("addr", dut_sram_write_address, e_addr);
      check_eq("data", dut_sram_write_data, e_data);
    end
  endtask

  task automatic step(input bit s, cv, cb, st, rr, inc, ec);
    start = s; conv_valid = cv; conv_bit = cb; str_temp_to_write = st;
    rst_output_row_temp = rr; incr_output_addr = inc; end_condition_met = ec;
    @(posedge clk);
    model_cycle(s, cv, cb, st, rr, inc, ec);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 0; conv_valid = 0; conv_bit = 0; str_temp_to_write = 0;
    rst_output_row_temp = 0; incr_output_addr = 0; end_condition_met = 0;
    @(posedge clk);
    m_phase = 0; m_bits.delete(); m_addr = 12'h000; m_ovf = 0; e_we = 0; e_done = 0;
    #1;
    reset = 1'b0;
    check_eq("rst_addr", dut_sram_write_address, 12'h000);
    check_eq("rst_data", dut_sram_write_data, 16'h0000);
    compare_outputs();
  endtask

  task automatic bit_in(input bit b);
    step(0, 1, b, 0, 0, 0, 0);
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();

    // 1: three bits 1,0,1 then commit
    step(1, 0, 0, 0, 0, 0, 0);
    bit_in(1); bit_in(0); bit_in(1);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t1_we", dut_sram_write_enable, 1'b1);
    check_eq("t1_addr", dut_sram_write_address, 12'h000);
    check_eq("t1_data", dut_sram_write_data, 16'hA000);

    // 2: 17 ones into a 16-column row
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) bit_in(1);
    check_eq("t2_ovf_pre", col_overflow, 1'b1);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t2_data", dut_sram_write_data, 16'hFFFF);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t2_next_row_empty", dut_sram_write_data, 16'h0000);

    // 3: commit plus skip at address 5
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    check_eq("t3_addr5", dut_sram_write_address, 12'h005);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t3_addr7", dut_sram_write_address, 12'h007);

    // 4: commit and end together at address 3
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
    bit_in(1);
    step(0, 0, 0, 1, 0, 0, 1);
    check_eq("t4_row_addr", dut_sram_write_address, 12'h003);
    check_eq("t4_row_data", dut_sram_write_data, 16'h8000);
    step(0, 0, 0, 1, 0, 1, 0);
    check_eq("t4_term_addr", dut_sram_write_address, 12'h004);
    check_eq("t4_term_data", dut_sram_write_data, 16'h00FF);
    idle_cycle();
    check_eq("t4_done", writer_done, 1'b1);
    idle_cycle();
    check_eq("t4_done_end", writer_done, 1'b0);

    // 5: reset mid-row, then strobes ignored until start
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) bit_in(1);
    do_reset();
    bit_in(1); bit_in(1);
    step(0, 0, 0, 1, 0, 1, 1);
    check_eq("t5_idle_we", dut_sram_write_enable, 1'b0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t5_fresh_addr", dut_sram_write_address, 12'h000);
    check_eq("t5_fresh_data", dut_sram_write_data, 16'h0000);

    // 6: clear beats a same-cycle bit
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0);
    bit_in(1);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("t6_data", dut_sram_write_data, 16'h8000);

    // address wrap at the top of the 12-bit space
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4095; i++) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("wrap_top", dut_sram_write_address, 12'hFFF);
    step(0, 0, 0, 1, 0, 0, 0);
    check_eq("wrap_zero", dut_sram_write_address, 12'h000);

    // randomized runs, with occasional mid-run resets and stray strobes
    for (int run = 0; run < 40; run++) begin
      int len;
      if ($urandom_range(0, 4) == 0) do_reset();
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      step(1, 0, 0, 0, 0, 0, 0);
      len = int'($urandom_range(10, 120));
      for (int c = 0; c < len; c++) begin
        bit st = ($urandom_range(0, 9) == 0);
        bit rr = ($urandom_range(0, 24) == 0);
        bit inc = ($urandom_range(0, 14) == 0);
        bit ec = (c == len - 1);
        if (run % 7 == 3 && c == len / 2) begin
          do_reset();
          break;
        end
        step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
             st, rr, inc, ec);
      end
      for (int i = 0; i < 3; i++)
        step($urandom_range(0, 3) == 0 && i == 2, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
      for (int i = 0; i < 4 && m_phase != 0; i++) step(0, 0, 0, 1, 0, 1, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
